// File: rtl/isolde_exec_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : isolde_exec_scheduler                                           |
// | Purpose  : Dispatches decoded ISOLDE requests to execution units, tracks    |
// |            busy units and, with ISOLDE_SCHED_SCOREBOARD_EN, QPR hazards.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module isolde_exec_scheduler #(
   parameter int NUM_UNITS = 3,
   parameter int RAW       = 5,
   parameter int STALL_W   = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic                           req_valid_i,
   output logic                           req_gnt_o,
   input  logic [$clog2(NUM_UNITS)-1:0]   req_unit_i,
   input  logic [RAW-1:0]                 req_rd_i,
   input  logic                           req_rd_we_i,
   input  logic [RAW-1:0]                 req_rs1_i,
   input  logic [RAW-1:0]                 req_rs2_i,
   input  logic [1:0]                     req_rs_use_i,
   output logic [NUM_UNITS-1:0]           unit_start_o,
   input  logic [NUM_UNITS-1:0]           unit_done_i,
   output logic [NUM_UNITS-1:0]           unit_busy_o,
   output logic [(2**RAW)-1:0]            pending_o,
   output logic [$clog2(NUM_UNITS+1)-1:0] outstanding_o,
   output logic [STALL_W-1:0]             stall_cnt_o,
   output logic                           busy_o
);

   localparam int                c_unit_w    = $clog2(NUM_UNITS);
   localparam int                c_cnt_w     = $clog2(NUM_UNITS+1);
   localparam int                c_nreg      = 2**RAW;
   localparam logic [c_unit_w:0] c_num_units = (c_unit_w+1)'(NUM_UNITS);

   logic [NUM_UNITS-1:0] r_busy;
   logic [NUM_UNITS-1:0] r_start;
   logic [STALL_W-1:0]   r_stall;

   logic                 w_unit_ok;
   logic                 w_unit_busy;
   logic                 w_hazard;
   logic                 w_gnt;
   logic [NUM_UNITS-1:0] w_set;
   logic [NUM_UNITS-1:0] w_clr;
   logic [c_cnt_w-1:0]   w_outstanding;

   // Out-of-range unit indices are treated as permanently busy so they never grant.
   assign w_unit_ok   = ({1'b0, req_unit_i} < c_num_units);
   assign w_unit_busy = w_unit_ok ? r_busy[req_unit_i] : 1'b1;
   assign w_gnt       = req_valid_i & ~flush_i & ~w_unit_busy & ~w_hazard;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (w_gnt && (req_unit_i == c_unit_w'(u))) begin
            w_set[u] = 1'b1;
         end
         w_clr[u] = unit_done_i[u] & r_busy[u];
      end
   end

   always_comb begin
      w_outstanding = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         w_outstanding = w_outstanding + c_cnt_w'(r_busy[u]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_busy  <= '0;
         r_start <= '0;
      end else if (flush_i) begin
         r_busy  <= '0;
         r_start <= '0;
      end else begin
         r_busy  <= (r_busy & ~w_clr) | w_set;
         r_start <= w_set;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall <= '0;
      end else if (flush_i) begin
         r_stall <= '0;
      end else if (req_valid_i && !w_gnt && (r_stall != '1)) begin
         r_stall <= r_stall + 1'b1;
      end
   end

`ifdef ISOLDE_SCHED_SCOREBOARD_EN
   logic [RAW-1:0]       r_rd [NUM_UNITS];
   logic [NUM_UNITS-1:0] r_rdwe;
   logic [c_nreg-1:0]    r_pending;
   logic [c_nreg-1:0]    w_pend_set;
   logic [c_nreg-1:0]    w_pend_clr;

   assign w_hazard = (req_rd_we_i     & r_pending[req_rd_i])
                   | (req_rs_use_i[0] & r_pending[req_rs1_i])
                   | (req_rs_use_i[1] & r_pending[req_rs2_i]);

   // Set and clear never target the same bit: the hazard check blocks a grant on a pending rd.
   always_comb begin
      w_pend_set = '0;
      w_pend_clr = '0;
      if (w_gnt && req_rd_we_i) begin
         w_pend_set[req_rd_i] = 1'b1;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (w_clr[u] && r_rdwe[u]) begin
            w_pend_clr[r_rd[u]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pending <= '0;
         r_rdwe    <= '0;
         for (int u = 0; u < NUM_UNITS; u++) begin
            r_rd[u] <= '0;
         end
      end else if (flush_i) begin
         r_pending <= '0;
         r_rdwe    <= '0;
         for (int u = 0; u < NUM_UNITS; u++) begin
            r_rd[u] <= '0;
         end
      end else begin
         r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_set[u]) begin
               r_rd[u]   <= req_rd_i;
               r_rdwe[u] <= req_rd_we_i;
            end
         end
      end
   end

   assign pending_o = r_pending;
`else
   logic w_unused;

   assign w_hazard  = 1'b0;
   assign pending_o = '0;
   assign w_unused  = ^{req_rd_i, req_rd_we_i, req_rs1_i, req_rs2_i, req_rs_use_i};
`endif

   assign req_gnt_o     = w_gnt;
   assign unit_start_o  = r_start;
   assign unit_busy_o   = r_busy;
   assign outstanding_o = w_outstanding;
   assign stall_cnt_o   = r_stall;
   assign busy_o        = |r_busy;

   a_unit_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   req_valid_i |-> w_unit_ok);

endmodule
`default_nettype wire

// File: tb/tb_isolde_exec_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_isolde_exec_scheduler                                        |
// | Purpose  : Directed self-checking bench for isolde_exec_scheduler.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_isolde_exec_scheduler;

`ifdef ISOLDE_SCHED_SCOREBOARD_EN
   localparam logic c_sb = 1'b1;
`else
   localparam logic c_sb = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        req_valid_i;
   logic        req_gnt_o;
   logic [1:0]  req_unit_i;
   logic [4:0]  req_rd_i;
   logic        req_rd_we_i;
   logic [4:0]  req_rs1_i;
   logic [4:0]  req_rs2_i;
   logic [1:0]  req_rs_use_i;
   logic [2:0]  unit_start_o;
   logic [2:0]  unit_done_i;
   logic [2:0]  unit_busy_o;
   logic [31:0] pending_o;
   logic [1:0]  outstanding_o;
   logic [15:0] stall_cnt_o;
   logic        busy_o;

   int n_chk = 0;
   int n_err = 0;

   isolde_exec_scheduler #(.NUM_UNITS(3), .RAW(5), .STALL_W(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_gnt_o(req_gnt_o), .req_unit_i(req_unit_i),
      .req_rd_i(req_rd_i), .req_rd_we_i(req_rd_we_i), .req_rs1_i(req_rs1_i),
      .req_rs2_i(req_rs2_i), .req_rs_use_i(req_rs_use_i),
      .unit_start_o(unit_start_o), .unit_done_i(unit_done_i),
      .unit_busy_o(unit_busy_o), .pending_o(pending_o),
      .outstanding_o(outstanding_o), .stall_cnt_o(stall_cnt_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [1:0] unit, input logic [4:0] rd, input logic we,
                      input logic [4:0] rs1, input logic [1:0] use_);
      req_valid_i  = 1'b1;
      req_unit_i   = unit;
      req_rd_i     = rd;
      req_rd_we_i  = we;
      req_rs1_i    = rs1;
      req_rs2_i    = 5'd0;
      req_rs_use_i = use_;
   endtask

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_unit_i = '0;
      req_rd_i = '0; req_rd_we_i = 1'b0; req_rs1_i = '0; req_rs2_i = '0;
      req_rs_use_i = '0; unit_done_i = '0;
      tick(); tick();
      chk("rst_gnt", 64'(req_gnt_o), 64'd0);
      chk("rst_start", 64'(unit_start_o), 64'd0);
      chk("rst_busy", 64'(unit_busy_o), 64'd0);
      chk("rst_pending", 64'(pending_o), 64'd0);
      chk("rst_outstanding", 64'(outstanding_o), 64'd0);
      chk("rst_stall", 64'(stall_cnt_o), 64'd0);
      chk("rst_busy_o", 64'(busy_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      // Idle dispatch to unit 1, rd=4
      req(2'd1, 5'd4, 1'b1, 5'd0, 2'b00);
      #1 chk("idle_gnt", 64'(req_gnt_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      #1 chk("idle_start", 64'(unit_start_o), 64'b010);
      chk("idle_pending", 64'(pending_o), c_sb ? 64'h10 : 64'd0);
      chk("idle_outstanding", 64'(outstanding_o), 64'd1);
      tick();
      chk("idle_start_width", 64'(unit_start_o), 64'd0);

      // Unit conflict on unit 1
      req(2'd1, 5'd5, 1'b0, 5'd0, 2'b00);
      #1 chk("conf_gnt0", 64'(req_gnt_o), 64'd0);
      tick();
      chk("conf_stall1", 64'(stall_cnt_o), 64'd1);
      tick();
      chk("conf_stall2", 64'(stall_cnt_o), 64'd2);
      unit_done_i = 3'b010;
      #1 chk("conf_gnt_done_cycle", 64'(req_gnt_o), 64'd0);
      tick();
      unit_done_i = 3'b000;
      #1 chk("conf_gnt_after_done", 64'(req_gnt_o), 64'd1);
      chk("conf_stall3", 64'(stall_cnt_o), 64'd3);
      chk("conf_pending_clr", 64'(pending_o), 64'd0);
      tick();
      req_valid_i = 1'b0;
      #1 chk("conf_start", 64'(unit_start_o), 64'b010);
      chk("conf_stall_hold", 64'(stall_cnt_o), 64'd3);
      unit_done_i = 3'b010;
      tick();
      unit_done_i = 3'b000;
      #1 chk("conf_release", 64'(unit_busy_o), 64'd0);

      // RAW hazard: unit 0 writes rd=7, unit 2 reads rs1=7
      req(2'd0, 5'd7, 1'b1, 5'd0, 2'b00);
      #1 chk("raw_gnt_u0", 64'(req_gnt_o), 64'd1);
      tick();
      req(2'd2, 5'd0, 1'b0, 5'd7, 2'b01);
`ifdef ISOLDE_SCHED_SCOREBOARD_EN
      #1 chk("raw_block0", 64'(req_gnt_o), 64'd0);
      tick();
      chk("raw_block1", 64'(req_gnt_o), 64'd0);
      unit_done_i = 3'b001;
      #1 chk("raw_block_done", 64'(req_gnt_o), 64'd0);
      tick();
      unit_done_i = 3'b000;
      #1 chk("raw_gnt_after", 64'(req_gnt_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      #1 chk("raw_busy", 64'(unit_busy_o), 64'b100);
`else
      #1 chk("raw_gnt_nosb", 64'(req_gnt_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      #1 chk("raw_busy", 64'(unit_busy_o), 64'b101);
`endif
      chk("raw_start_u2", 64'(unit_start_o), 64'b100);
      unit_done_i = 3'b101;
      tick();
      unit_done_i = 3'b000;
      #1 chk("raw_clean_busy", 64'(unit_busy_o), 64'd0);
      chk("raw_clean_pending", 64'(pending_o), 64'd0);

      // Parallel dispatch to all three units
      req(2'd0, 5'd1, 1'b1, 5'd0, 2'b00);
      #1 chk("par_gnt0", 64'(req_gnt_o), 64'd1);
      tick();
      req(2'd1, 5'd2, 1'b1, 5'd0, 2'b00);
      #1 chk("par_gnt1", 64'(req_gnt_o), 64'd1);
      tick();
      req(2'd2, 5'd3, 1'b1, 5'd0, 2'b00);
      #1 chk("par_gnt2", 64'(req_gnt_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
      #1 chk("par_outstanding3", 64'(outstanding_o), 64'd3);
      chk("par_busy_o", 64'(busy_o), 64'd1);
      chk("par_pending", 64'(pending_o), c_sb ? 64'b1110 : 64'd0);
      unit_done_i = 3'b101;
      tick();
      unit_done_i = 3'b000;
      #1 chk("par_outstanding1", 64'(outstanding_o), 64'd1);
      chk("par_busy_left", 64'(unit_busy_o), 64'b010);
      chk("par_pending_left", 64'(pending_o), c_sb ? 64'b0100 : 64'd0);

      // Flush with units 0 and 1 busy
      req(2'd0, 5'd9, 1'b1, 5'd0, 2'b00);
      #1 chk("fl_pre_gnt", 64'(req_gnt_o), 64'd1);
      tick();
      req(2'd2, 5'd10, 1'b1, 5'd0, 2'b00);
      flush_i = 1'b1;
      #1 chk("fl_no_gnt", 64'(req_gnt_o), 64'd0);
      tick();
      flush_i = 1'b0;
      req_valid_i = 1'b0;
      #1 chk("fl_busy", 64'(unit_busy_o), 64'd0);
      chk("fl_pending", 64'(pending_o), 64'd0);
      chk("fl_outstanding", 64'(outstanding_o), 64'd0);
      chk("fl_stall", 64'(stall_cnt_o), 64'd0);
      chk("fl_start", 64'(unit_start_o), 64'd0);
      chk("fl_busy_o", 64'(busy_o), 64'd0);
      unit_done_i = 3'b011;
      tick();
      unit_done_i = 3'b000;
      #1 chk("fl_stray_done", 64'(unit_busy_o), 64'd0);
      chk("fl_stray_outstanding", 64'(outstanding_o), 64'd0);
      req(2'd1, 5'd2, 1'b1, 5'd0, 2'b00);
      #1 chk("fl_regrant", 64'(req_gnt_o), 64'd1);
      tick();

      // Stall counter saturation on busy unit 1
      req(2'd1, 5'd0, 1'b0, 5'd0, 2'b00);
      repeat (65534) tick();
      chk("sat_fffe", 64'(stall_cnt_o), 64'hFFFE);
      tick();
      chk("sat_ffff", 64'(stall_cnt_o), 64'hFFFF);
      repeat (6) tick();
      chk("sat_hold", 64'(stall_cnt_o), 64'hFFFF);
      chk("sat_gnt", 64'(req_gnt_o), 64'd0);

      // Asynchronous reset mid-operation
      #2 rst_ni = 1'b0;
      #1 chk("arst_busy", 64'(unit_busy_o), 64'd0);
      chk("arst_stall", 64'(stall_cnt_o), 64'd0);
      chk("arst_outstanding", 64'(outstanding_o), 64'd0);
      req_valid_i = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
